// File: rtl/conv_layer_scheduler.sv
// Sequences one conv layer: per kernel, load weights, pulse conv start, wait for done, advance.
// Latency: layer_start->load req 1 cycle, ack->conv_start 1 cycle, conv_done->next req 2 cycles.
// Backpressure: waits indefinitely for kernel_load_ack; RUN is bounded by a watchdog; abort wins.
module conv_layer_scheduler #(
    parameter int NUM_KERNELS    = 4,
    parameter int KIDX_BW        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               layer_start,
    input  logic               abort,
    output logic               kernel_load_req,
    input  logic               kernel_load_ack,
    output logic               conv_start,
    input  logic               conv_done,
    output logic [KIDX_BW-1:0] kernel_index,
    output logic               layer_busy,
    output logic               layer_done,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Watchdog leaves RUN on this count, so the 16-bit counter can never wrap.
    localparam logic [15:0]        WD_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [KIDX_BW-1:0] KIDX_LAST = KIDX_BW'(NUM_KERNELS - 1);

    state_t               state_q, state_d;
    logic [KIDX_BW-1:0]   kidx_q, kidx_d;
    logic [15:0]          wd_q, wd_d;
    logic                 terr_q, terr_d;

    // State, kernel index, watchdog and sticky error registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            kidx_q  <= '0;
            wd_q    <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kidx_q  <= kidx_d;
            wd_q    <= wd_d;
            terr_q  <= terr_d;
        end
    end

    // Next-state logic; abort is applied last so it overrides every other transition.
    always_comb begin
        state_d = state_q;
        kidx_d  = kidx_q;
        wd_d    = wd_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: begin
                if (layer_start) begin
                    state_d = S_LOAD;
                    kidx_d  = '0;
                    terr_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (kernel_load_ack) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_RUN;
                wd_d    = '0;
            end
            S_RUN: begin
                wd_d = wd_q + 16'd1;
                // A done arriving on the expiry cycle still counts as success.
                if (conv_done) begin
                    state_d = S_NEXT;
                end else if (wd_q == WD_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_NEXT: begin
                if (kidx_q == KIDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    kidx_d  = kidx_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                kidx_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                kidx_d  = '0;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
            kidx_d  = '0;
        end
    end

    // Outputs decoded purely from registered state, so they are glitch-free.
    assign kernel_load_req = (state_q == S_LOAD);
    assign conv_start      = (state_q == S_START);
    assign layer_busy      = (state_q != S_IDLE);
    assign layer_done      = (state_q == S_DONE);
    assign kernel_index    = kidx_q;
    assign timeout_err     = terr_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: three instances cover NUM_KERNELS=4 with a
// long watchdog, NUM_KERNELS=4 with a 16-cycle watchdog, and NUM_KERNELS=1.
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
module tb_conv_layer_scheduler;

    localparam int N = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       ls    [N];
    logic       ab    [N];
    logic       ack   [N];
    logic       done  [N];
    logic       req   [N];
    logic       cst   [N];
    logic       busy  [N];
    logic       ldone [N];
    logic       terr  [N];
    logic [1:0] kidx  [N];

    int cnt_cst [N] = '{0, 0, 0};
    int cnt_ld  [N] = '{0, 0, 0};
    int n_vec = 0;
    int n_err = 0;
    int u = 0;
    int base_cst;
    int base_ld;

    conv_layer_scheduler #(.NUM_KERNELS(4), .KIDX_BW(2), .TIMEOUT_CYCLES(1024)) dut0 (
        .clock(clock), .reset(reset), .layer_start(ls[0]), .abort(ab[0]),
        .kernel_load_req(req[0]), .kernel_load_ack(ack[0]), .conv_start(cst[0]),
        .conv_done(done[0]), .kernel_index(kidx[0]), .layer_busy(busy[0]),
        .layer_done(ldone[0]), .timeout_err(terr[0]));

    conv_layer_scheduler #(.NUM_KERNELS(4), .KIDX_BW(2), .TIMEOUT_CYCLES(16)) dut1 (
        .clock(clock), .reset(reset), .layer_start(ls[1]), .abort(ab[1]),
        .kernel_load_req(req[1]), .kernel_load_ack(ack[1]), .conv_start(cst[1]),
        .conv_done(done[1]), .kernel_index(kidx[1]), .layer_busy(busy[1]),
        .layer_done(ldone[1]), .timeout_err(terr[1]));

    conv_layer_scheduler #(.NUM_KERNELS(1), .KIDX_BW(2), .TIMEOUT_CYCLES(1024)) dut2 (
        .clock(clock), .reset(reset), .layer_start(ls[2]), .abort(ab[2]),
        .kernel_load_req(req[2]), .kernel_load_ack(ack[2]), .conv_start(cst[2]),
        .conv_done(done[2]), .kernel_index(kidx[2]), .layer_busy(busy[2]),
        .layer_done(ldone[2]), .timeout_err(terr[2]));

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (cst[i])   cnt_cst[i] = cnt_cst[i] + 1;
            if (ldone[i]) cnt_ld[i]  = cnt_ld[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s (dut%0d): got %0d, expected %0d at %0t", tag, u, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_layer();
        ls[u] = 1'b1;
        tick();
        ls[u] = 1'b0;
    endtask

    // Expects to be in LOAD; acks after ack_dly cycles and checks the conv_start pulse.
    task automatic load_and_start(input int exp_k, input int ack_dly);
        chk("load_req", 32'(req[u]), 1);
        chk("load_kidx", 32'(kidx[u]), exp_k);
        repeat (ack_dly - 1) tick();
        chk("load_hold", 32'(req[u]), 1);
        ack[u] = 1'b1;
        tick();
        ack[u] = 1'b0;
        chk("cst_pulse", 32'(cst[u]), 1);
        chk("req_drop", 32'(req[u]), 0);
    endtask

    // Expects to be in START; raises conv_done done_dly cycles later, ends in NEXT.
    task automatic finish_conv(input int done_dly);
        repeat (done_dly - 1) tick();
        chk("cst_single", 32'(cst[u]), 0);
        chk("run_busy", 32'(busy[u]), 1);
        done[u] = 1'b1;
        tick();
        done[u] = 1'b0;
        chk("next_busy", 32'(busy[u]), 1);
        chk("next_noreq", 32'(req[u]), 0);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            ls[i] = 1'b0; ab[i] = 1'b0; ack[i] = 1'b0; done[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < N; i++) begin
            u = i;
            chk("rst_req", 32'(req[i]), 0);
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_kidx", 32'(kidx[i]), 0);
            chk("rst_terr", 32'(terr[i]), 0);
        end
        reset = 1'b1;
        tick();

        // Full four-kernel layer, ack 3 cycles after req, done 20 cycles after start.
        u = 0;
        base_cst = cnt_cst[0];
        base_ld  = cnt_ld[0];
        start_layer();
        chk("busy_after_start", 32'(busy[0]), 1);
        for (int k = 0; k < 4; k++) begin
            load_and_start(k, 3);
            finish_conv(20);
            tick();
            if (k < 3) begin
                chk("next_req", 32'(req[0]), 1);
                chk("next_kidx", 32'(kidx[0]), k + 1);
            end else begin
                chk("layer_done", 32'(ldone[0]), 1);
                chk("done_kidx", 32'(kidx[0]), 3);
                tick();
                chk("done_single", 32'(ldone[0]), 0);
                chk("busy_drop", 32'(busy[0]), 0);
                chk("idle_kidx", 32'(kidx[0]), 0);
            end
        end
        chk("cst_count4", 32'(cnt_cst[0] - base_cst), 4);
        chk("ld_count1", 32'(cnt_ld[0] - base_ld), 1);

        // Asynchronous reset while running kernel 2.
        start_layer();
        load_and_start(0, 1);
        finish_conv(4);
        tick();
        load_and_start(1, 1);
        finish_conv(4);
        tick();
        load_and_start(2, 2);
        tick();
        chk("mid_run_kidx", 32'(kidx[0]), 2);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy[0]), 0);
        chk("arst_kidx", 32'(kidx[0]), 0);
        chk("arst_req", 32'(req[0]), 0);
        chk("arst_cst", 32'(cst[0]), 0);
        #3 reset = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy[0]), 0);
        start_layer();
        chk("restart_kidx", 32'(kidx[0]), 0);
        chk("restart_req", 32'(req[0]), 1);
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        chk("abort_idle", 32'(busy[0]), 0);

        // Abort in LOAD of kernel 1 together with ack.
        base_cst = cnt_cst[0];
        base_ld  = cnt_ld[0];
        start_layer();
        load_and_start(0, 1);
        finish_conv(3);
        tick();
        chk("k1_load", 32'(kidx[0]), 1);
        ack[0] = 1'b1;
        ab[0]  = 1'b1;
        tick();
        ack[0] = 1'b0;
        ab[0]  = 1'b0;
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_kidx", 32'(kidx[0]), 0);
        chk("abort_nocst", 32'(cst[0]), 0);
        tick();
        chk("abort_cst_count", 32'(cnt_cst[0] - base_cst), 1);
        chk("abort_no_ldone", 32'(cnt_ld[0] - base_ld), 0);

        // layer_start during RUN is ignored; spurious ack in RUN and done in LOAD too.
        start_layer();
        load_and_start(0, 2);
        tick();
        ls[0] = 1'b1;
        tick();
        ls[0] = 1'b0;
        chk("ign_start_busy", 32'(busy[0]), 1);
        chk("ign_start_req", 32'(req[0]), 0);
        chk("ign_start_cst", 32'(cst[0]), 0);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        chk("ign_ack_req", 32'(req[0]), 0);
        chk("ign_ack_cst", 32'(cst[0]), 0);
        chk("ign_ack_busy", 32'(busy[0]), 1);
        done[0] = 1'b1;
        tick();
        done[0] = 1'b0;
        tick();
        chk("adv_kidx", 32'(kidx[0]), 1);
        done[0] = 1'b1;
        tick();
        done[0] = 1'b0;
        chk("ign_done_req", 32'(req[0]), 1);
        chk("ign_done_kidx", 32'(kidx[0]), 1);
        chk("ign_done_cst", 32'(cst[0]), 0);
        ab[0] = 1'b1;
        tick();
        ls[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        ls[0] = 1'b0;
        chk("abort_over_start", 32'(busy[0]), 0);

        // Watchdog expiry with a 16-cycle limit.
        u = 1;
        base_ld = cnt_ld[1];
        start_layer();
        load_and_start(0, 1);
        repeat (16) tick();
        chk("wd_still_run", 32'(busy[1]), 1);
        chk("wd_no_err_yet", 32'(terr[1]), 0);
        tick();
        chk("wd_idle", 32'(busy[1]), 0);
        chk("wd_err", 32'(terr[1]), 1);
        chk("wd_no_ldone", 32'(ldone[1]), 0);
        start_layer();
        chk("err_cleared", 32'(terr[1]), 0);

        // conv_done on the expiry cycle wins.
        load_and_start(0, 1);
        repeat (16) tick();
        done[1] = 1'b1;
        tick();
        done[1] = 1'b0;
        chk("tie_no_err", 32'(terr[1]), 0);
        chk("tie_busy", 32'(busy[1]), 1);
        chk("tie_noreq", 32'(req[1]), 0);
        tick();
        chk("tie_next_req", 32'(req[1]), 1);
        chk("tie_next_kidx", 32'(kidx[1]), 1);
        load_and_start(1, 1);
        repeat (17) tick();
        chk("wd2_err", 32'(terr[1]), 1);
        ab[1] = 1'b1;
        tick();
        ab[1] = 1'b0;
        chk("abort_keeps_err", 32'(terr[1]), 1);
        chk("wd_ldone_count", 32'(cnt_ld[1] - base_ld), 0);

        // Single-kernel layer.
        u = 2;
        base_cst = cnt_cst[2];
        base_ld  = cnt_ld[2];
        start_layer();
        load_and_start(0, 2);
        finish_conv(5);
        tick();
        chk("nk1_ldone", 32'(ldone[2]), 1);
        chk("nk1_kidx", 32'(kidx[2]), 0);
        tick();
        chk("nk1_idle", 32'(busy[2]), 0);
        chk("nk1_kidx_idle", 32'(kidx[2]), 0);
        chk("nk1_cst_count", 32'(cnt_cst[2] - base_cst), 1);
        chk("nk1_ld_count", 32'(cnt_ld[2] - base_ld), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
